voxel_gpu_fill_engine: RTL and testbench

Second-generation voxel GPU front end with parametrised frame geometry. It keeps the Avalon-MM slave register file for front/back pixel-buffer pointers and adds an Avalon-MM write master that fills the back buffer with a solid colour. It can then swap front and back pointers and raise an interrupt. It sits between the HPS lightweight bridge (slave) and SDRAM (master), ahead of the pixel DMA that scans out the front buffer.

---
 rtl/voxel_gpu_fill_engine.sv | 140 ++++++++++++++
 tb/tb_voxel_gpu_fill_engine.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/voxel_gpu_fill_engine.sv
// Voxel GPU front end: front/back pointer registers plus a write master that paints the back buffer
// one word per accepted cycle. m1_waitrequest stalls the fill and holds address and data; an optional swap and the irq follow.
module voxel_gpu_fill_engine #(
  parameter logic [31:0] DEFAULT_BUFFER      = 32'h0800_0000,
  parameter logic [31:0] DEFAULT_BACK_BUFFER = 32'h0800_0000,
  parameter logic [15:0] H_RESOLUTION        = 16'd256,
  parameter logic [15:0] V_RESOLUTION        = 16'd192,
  parameter int          PIXEL_BYTES         = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  s1_address,
  input  logic [31:0] s1_writedata,
  input  logic        s1_write,
  output logic [31:0] s1_readdata,
  output logic        s1_waitrequest,
  output logic        irq,
  output logic [31:0] m1_address,
  output logic [31:0] m1_writedata,
  output logic [3:0]  m1_byteenable,
  output logic        m1_write,
  output logic        m1_read,
  input  logic        m1_waitrequest,
  input  logic [31:0] m1_readdata,
  input  logic        m1_readdatavalid
);
  localparam longint FRAME_BYTES = longint'(H_RESOLUTION) * longint'(V_RESOLUTION) * longint'(PIXEL_BYTES);
  localparam int WORDS = int'(FRAME_BYTES / 4);
  localparam int CW = (WORDS < 1) ? 1 : $clog2(WORDS + 1);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  if (!(PIXEL_BYTES == 1 || PIXEL_BYTES == 2 || PIXEL_BYTES == 4) ||
      (FRAME_BYTES % 4 != 0) || (WORDS < 1)) begin : g_bad_geometry
    $error("voxel_gpu_fill_engine: frame must be a whole number (>=1) of 32-bit words, PIXEL_BYTES 1, 2 or 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_SWAP} state_t;

  state_t          state, state_nxt;
  logic [31:0]     front_ptr, back_ptr, fill_colour, fill_word, addr;
  logic [CW-1:0]   count;
  logic            swap_after, irq_en, irq_pending;
  logic            idle, accept, last_word, set_pending, start;
  logic            wr_front, wr_back, wr_fill, wr_ctrl, wr_status;
  logic            unused_inputs;

  assign wr_front  = s1_write && (s1_address == 8'd0);
  assign wr_back   = s1_write && (s1_address == 8'd1);
  assign wr_fill   = s1_write && (s1_address == 8'd2);
  assign wr_ctrl   = s1_write && (s1_address == 8'd3);
  assign wr_status = s1_write && (s1_address == 8'd4);

  assign idle        = (state == S_IDLE);
  assign start       = wr_ctrl && idle && s1_writedata[0];
  assign accept      = m1_write && !m1_waitrequest;
  assign last_word   = accept && (count == LAST);
  assign set_pending = (state == S_SWAP) || (last_word && !swap_after);

  if (PIXEL_BYTES == 1) begin : g_pb1
    assign fill_word = {4{fill_colour[7:0]}};
  end else if (PIXEL_BYTES == 2) begin : g_pb2
    assign fill_word = {2{fill_colour[15:0]}};
  end else begin : g_pb4
    assign fill_word = fill_colour;
  end

  assign s1_waitrequest = 1'b0;
  assign irq            = irq_pending && irq_en;
  assign m1_write       = (state == S_FILL);
  assign m1_address     = addr;
  assign m1_writedata   = fill_word;
  assign m1_byteenable  = 4'hF;
  assign m1_read        = 1'b0;
  assign unused_inputs  = ^{m1_readdata, m1_readdatavalid};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (wr_ctrl && s1_writedata[0])      state_nxt = S_FILL;
        else if (wr_ctrl && s1_writedata[1]) state_nxt = S_SWAP;
      end
      S_FILL:  if (last_word) state_nxt = swap_after ? S_SWAP : S_IDLE;
      S_SWAP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      front_ptr   <= DEFAULT_BUFFER;
      back_ptr    <= DEFAULT_BACK_BUFFER;
      fill_colour <= 32'd0;
      addr        <= 32'd0;
      count       <= '0;
      swap_after  <= 1'b0;
      irq_en      <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= s1_writedata[2];
      if (start) begin
        addr       <= back_ptr;
        count      <= '0;
        swap_after <= s1_writedata[1];
      end else if (accept) begin
        addr  <= addr + 32'd4;
        count <= count + CW'(1);
      end
      // The exchange takes priority over a host FRONT write landing in the same cycle.
      if (state == S_SWAP) begin
        front_ptr <= back_ptr;
        back_ptr  <= front_ptr;
      end else begin
        if (wr_front)         front_ptr <= s1_writedata;
        if (wr_back && idle)  back_ptr  <= s1_writedata;
      end
      if (wr_fill && idle) fill_colour <= s1_writedata;
      if (set_pending)                        irq_pending <= 1'b1;
      else if (wr_status && s1_writedata[1])  irq_pending <= 1'b0;
    end
  end

  always_comb begin
    s1_readdata = 32'd0;
    case (s1_address)
      8'd0:    s1_readdata = front_ptr;
      8'd1:    s1_readdata = back_ptr;
      8'd2:    s1_readdata = fill_colour;
      8'd3:    s1_readdata = {29'd0, irq_en, 2'b00};
      8'd4:    s1_readdata = {30'd0, irq_pending, !idle};
      8'd5:    s1_readdata = {V_RESOLUTION, H_RESOLUTION};
      default: s1_readdata = 32'd0;
    endcase
  end
endmodule

// File: tb/tb_voxel_gpu_fill_engine.sv
// Directed bench: register vectors from a table, then hand-written fill, stall, swap, reset and 8-bit-pixel sequences.
module tb_voxel_gpu_fill_engine;
  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  s1_address;
  logic [31:0] s1_writedata;
  logic        s1_write;
  logic        m1_waitrequest;
  logic [31:0] m1_readdata;
  logic        m1_readdatavalid;

  logic [31:0] s1_readdata, m1_address, m1_writedata;
  logic        s1_waitrequest, irq, m1_write, m1_read;
  logic [3:0]  m1_byteenable;
  logic [31:0] b_s1_readdata, b_m1_address, b_m1_writedata;
  logic        b_s1_waitrequest, b_irq, b_m1_write, b_m1_read;
  logic [3:0]  b_m1_byteenable;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clock = ~clock;

  voxel_gpu_fill_engine #(.H_RESOLUTION(16'd4), .V_RESOLUTION(16'd2), .PIXEL_BYTES(2)) u_dut (
    .clock(clock), .reset(reset),
    .s1_address(s1_address), .s1_writedata(s1_writedata), .s1_write(s1_write),
    .s1_readdata(s1_readdata), .s1_waitrequest(s1_waitrequest), .irq(irq),
    .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_write(m1_write), .m1_read(m1_read), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid)
  );

  voxel_gpu_fill_engine #(.H_RESOLUTION(16'd4), .V_RESOLUTION(16'd2), .PIXEL_BYTES(1)) u_dut_b (
    .clock(clock), .reset(reset),
    .s1_address(s1_address), .s1_writedata(s1_writedata), .s1_write(s1_write),
    .s1_readdata(b_s1_readdata), .s1_waitrequest(b_s1_waitrequest), .irq(b_irq),
    .m1_address(b_m1_address), .m1_writedata(b_m1_writedata), .m1_byteenable(b_m1_byteenable),
    .m1_write(b_m1_write), .m1_read(b_m1_read), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    s1_address   = a;
    s1_writedata = d;
    s1_write     = 1'b1;
    @(negedge clock);
    s1_write     = 1'b0;
  endtask

  task automatic rd(input logic sel_b, input logic [7:0] a, input logic [31:0] exp, input string name);
    s1_address = a;
    #1;
    chk32(name, sel_b ? b_s1_readdata : s1_readdata, exp);
  endtask

  initial begin
    int acc;
    int extra;
    logic        ws[7];
    logic [31:0] ea[7];

    vecs[0]  = '{1'b0, 8'd0, 32'd0,           32'h0800_0000};
    vecs[1]  = '{1'b0, 8'd1, 32'd0,           32'h0800_0000};
    vecs[2]  = '{1'b0, 8'd2, 32'd0,           32'h0000_0000};
    vecs[3]  = '{1'b0, 8'd3, 32'd0,           32'h0000_0000};
    vecs[4]  = '{1'b0, 8'd4, 32'd0,           32'h0000_0000};
    vecs[5]  = '{1'b0, 8'd5, 32'd0,           32'h0002_0004};
    vecs[6]  = '{1'b1, 8'd0, 32'h1111_2222,   32'd0};
    vecs[7]  = '{1'b0, 8'd0, 32'd0,           32'h1111_2222};
    vecs[8]  = '{1'b1, 8'd2, 32'hDEAD_BEEF,   32'd0};
    vecs[9]  = '{1'b0, 8'd2, 32'd0,           32'hDEAD_BEEF};
    vecs[10] = '{1'b1, 8'd6, 32'hFFFF_FFFF,   32'd0};
    vecs[11] = '{1'b0, 8'd6, 32'd0,           32'h0000_0000};
    vecs[12] = '{1'b1, 8'd5, 32'h0000_0000,   32'd0};
    vecs[13] = '{1'b0, 8'd5, 32'd0,           32'h0002_0004};
    vecs[14] = '{1'b1, 8'd3, 32'h0000_0004,   32'd0};
    vecs[15] = '{1'b0, 8'd3, 32'd0,           32'h0000_0004};
    vecs[16] = '{1'b0, 8'd4, 32'd0,           32'h0000_0000};
    vecs[17] = '{1'b1, 8'd3, 32'h0000_0000,   32'd0};

    reset = 1'b1;
    s1_address = 8'd0; s1_writedata = 32'd0; s1_write = 1'b0;
    m1_waitrequest = 1'b0; m1_readdata = 32'd0; m1_readdatavalid = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk1("rst_m1_write", m1_write, 1'b0);
    chk1("rst_irq", irq, 1'b0);
    chk32("rst_m1_address", m1_address, 32'd0);
    chk32("rst_m1_writedata", m1_writedata, 32'd0);
    chk32("rst_byteenable", {28'd0, m1_byteenable}, 32'hF);
    chk1("rst_m1_read", m1_read, 1'b0);
    chk1("rst_waitreq", s1_waitrequest, 1'b0);
    chk1("rst_b_m1_write", b_m1_write | b_m1_read | b_s1_waitrequest | b_irq, 1'b0);
    chk32("rst_b_byteenable", {28'd0, b_m1_byteenable}, 32'hF);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data);
      else            rd(1'b0, vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_read", i));
    end

    // Unstalled fill of four words, irq on completion, W1C clear.
    wr(8'd1, 32'h1000); wr(8'd2, 32'hABCD); wr(8'd3, 32'h5);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("t2_write", m1_write, 1'b1);
      chk32("t2_addr", m1_address, 32'h1000 + 32'(4 * i));
      chk32("t2_data", m1_writedata, 32'hABCD_ABCD);
      @(negedge clock);
    end
    #1;
    chk1("t2_done_write", m1_write, 1'b0);
    chk1("t2_irq", irq, 1'b1);
    rd(1'b0, 8'd4, 32'h2, "t2_status");
    wr(8'd4, 32'h2);
    #1;
    chk1("t2_irq_cleared", irq, 1'b0);
    rd(1'b0, 8'd4, 32'h0, "t2_status_cleared");

    // Three-cycle stall on the second word.
    ws = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ea = '{32'h1000, 32'h1004, 32'h1004, 32'h1004, 32'h1004, 32'h1008, 32'h100C};
    wr(8'd3, 32'h5);
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      m1_waitrequest = ws[i];
      #1;
      chk1("t3_write", m1_write, 1'b1);
      chk32("t3_addr", m1_address, ea[i]);
      chk32("t3_data", m1_writedata, 32'hABCD_ABCD);
      if (m1_write && !m1_waitrequest) acc++;
      @(negedge clock);
    end
    m1_waitrequest = 1'b0;
    #1;
    chk1("t3_done_write", m1_write, 1'b0);
    chk32("t3_accepted", acc, 32'd4);
    wr(8'd4, 32'h2);

    // Fill then swap; writes during busy ignored except irq_en; FRONT write during SWAP loses.
    wr(8'd0, 32'hA000); wr(8'd1, 32'hB000); wr(8'd3, 32'h3);
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin s1_address = 8'd2; s1_writedata = 32'h5555; s1_write = 1'b1; end
        1: begin s1_address = 8'd1; s1_writedata = 32'h1234; s1_write = 1'b1; end
        2: begin s1_address = 8'd3; s1_writedata = 32'h5;    s1_write = 1'b1; end
        default: s1_write = 1'b0;
      endcase
      #1;
      chk1("t4_write", m1_write, 1'b1);
      chk32("t4_addr", m1_address, 32'hB000 + 32'(4 * i));
      chk32("t4_data", m1_writedata, 32'hABCD_ABCD);
      @(negedge clock);
      s1_write = 1'b0;
    end
    #1;
    chk1("t4_swap_write", m1_write, 1'b0);
    rd(1'b0, 8'd4, 32'h1, "t4_status_swap");
    wr(8'd0, 32'hEEEE);
    rd(1'b0, 8'd0, 32'hB000, "t4_front");
    rd(1'b0, 8'd1, 32'hA000, "t4_back");
    rd(1'b0, 8'd4, 32'h2, "t4_status_done");
    rd(1'b0, 8'd2, 32'hABCD, "t4_fill_kept");
    rd(1'b0, 8'd3, 32'h4, "t4_irq_en");
    chk1("t4_irq", irq, 1'b1);
    chk1("t4_no_restart", m1_write, 1'b0);
    wr(8'd4, 32'h2);

    // Reset after two accepted words.
    wr(8'd1, 32'h2000); wr(8'd3, 32'h1);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk32("t5_addr", m1_address, 32'h2000 + 32'(4 * i));
      @(negedge clock);
    end
    #1;
    chk1("t5_third_pending", m1_write, 1'b1);
    reset = 1'b1;
    #1;
    chk1("t5_write_async", m1_write, 1'b0);
    chk32("t5_addr_rst", m1_address, 32'd0);
    rd(1'b0, 8'd4, 32'h0, "t5_status");
    rd(1'b0, 8'd0, 32'h0800_0000, "t5_front");
    @(negedge clock);
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (m1_write) extra++;
      @(negedge clock);
    end
    chk32("t5_no_writes", extra, 32'd0);
    rd(1'b0, 8'd1, 32'h0800_0000, "t5_back");

    // 8-bit pixels, then a swap-only command.
    wr(8'd2, 32'h12); wr(8'd3, 32'h1);
    #1;
    chk1("t6_b_write", b_m1_write, 1'b1);
    chk32("t6_b_data", b_m1_writedata, 32'h1212_1212);
    chk32("t6_b_addr0", b_m1_address, 32'h0800_0000);
    chk32("t6_a_data", m1_writedata, 32'h0012_0012);
    @(negedge clock);
    #1;
    chk32("t6_b_addr1", b_m1_address, 32'h0800_0004);
    @(negedge clock);
    #1;
    chk1("t6_b_done", b_m1_write, 1'b0);
    chk1("t6_b_irq_masked", b_irq, 1'b0);
    rd(1'b1, 8'd4, 32'h2, "t6_b_status");
    repeat (2) @(negedge clock);
    #1;
    chk1("t6_a_done", m1_write, 1'b0);
    wr(8'd4, 32'h2);
    wr(8'd0, 32'h3000);
    wr(8'd3, 32'h2);
    rd(1'b1, 8'd4, 32'h1, "t6_swap_busy");
    rd(1'b1, 8'd0, 32'h3000, "t6_front_pre");
    @(negedge clock);
    rd(1'b1, 8'd0, 32'h0800_0000, "t6_front_post");
    rd(1'b1, 8'd1, 32'h3000, "t6_back_post");
    rd(1'b1, 8'd4, 32'h2, "t6_status_post");
    chk1("t6_no_fill", b_m1_write, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
